// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller (master) and memory (slave).
interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: FETCH/DELIVER/ERROR sequencer with text-segment range checking.
// Define PC_FETCH_TRAP_EN to make ERROR a one-cycle trap to TRAP_PC instead of a terminal state.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h00400000,
   parameter logic [31:0] TEXT_BASE = 32'h00400000,
   parameter logic [31:0] TEXT_LAST = 32'h00400FFF
`ifdef PC_FETCH_TRAP_EN
   ,parameter logic [31:0] TRAP_PC  = 32'h00400180
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   pc_fetch_ctrl_if.master       imem,
   output logic                  inst_valid,
   output logic [31:0]           inst,
   output logic [31:0]           inst_pc,
   output logic [31:0]           pc,
   output logic                  invalid_pc,
   output logic [31:0]           bad_pc
);

   typedef enum logic [1:0] {FETCH, DELIVER, ERROR} state_t;

   state_t state;
   logic   pc_ok;

   assign pc_ok          = (pc >= TEXT_BASE) && (pc <= TEXT_LAST) && (pc[1:0] == 2'b00);
   assign imem.imem_req  = (state == FETCH) && pc_ok;
   assign imem.imem_addr = pc[11:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
         invalid_pc <= 1'b0;
         bad_pc     <= '0;
      end else begin
         case (state)
            FETCH: begin
               // A taken redirect beats everything, including a same-cycle memory return.
               if (redirect_valid) begin
                  pc         <= redirect_pc;
                  inst_valid <= 1'b0;
               end else if (!pc_ok) begin
                  state      <= ERROR;
                  bad_pc     <= pc;
                  invalid_pc <= 1'b1;
               end else if (imem.imem_ready) begin
                  inst       <= imem.imem_rdata;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  state      <= DELIVER;
               end
            end
            DELIVER: begin
               if (redirect_valid) begin
                  pc         <= redirect_pc;
                  inst_valid <= 1'b0;
                  state      <= FETCH;
               end else if (!stall) begin
                  pc         <= pc + 32'd4;
                  inst_valid <= 1'b0;
                  state      <= FETCH;
               end
            end
            ERROR: begin
               inst_valid <= 1'b0;
`ifdef PC_FETCH_TRAP_EN
               invalid_pc <= 1'b0;
               pc         <= TRAP_PC;
               state      <= FETCH;
`else
               invalid_pc <= 1'b1;
`endif
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed table-driven bench for pc_fetch_ctrl; follows PC_FETCH_TRAP_EN for the error path.
module tb_pc_fetch_ctrl;

   typedef struct {
      logic        rst, stall, rv;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] rdata;
      logic        req;
      logic [9:0]  addr;
      logic        iv;
      logic [31:0] inst, ipc, pc;
      logic        inv;
      logic [31:0] bad;
   } vec_t;

   localparam logic [31:0] R  = 32'h00400000;
   localparam logic [31:0] DA = 32'h11111111;
   localparam logic [31:0] DB = 32'h22222222;
   localparam logic [31:0] DC = 32'h33333333;
   localparam logic [31:0] DD = 32'h44444444;
   localparam logic [31:0] DE = 32'h55555555;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, invalid_pc;
   logic [31:0] inst, inst_pc, pc, bad_pc;
   int          n_tests = 0;
   int          n_fail  = 0;

   pc_fetch_ctrl_if imem_bus ();

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem(imem_bus), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .pc(pc), .invalid_pc(invalid_pc), .bad_pc(bad_pc)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic st, logic rv, logic [31:0] rpc, logic rdy,
                               logic [31:0] rdata, logic req, logic [9:0] addr, logic iv,
                               logic [31:0] ins, logic [31:0] ipc, logic [31:0] p,
                               logic inv, logic [31:0] bad);
      vec_t v;
      v.rst = r; v.stall = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
      v.req = req; v.addr = addr; v.iv = iv; v.inst = ins; v.ipc = ipc; v.pc = p;
      v.inv = inv; v.bad = bad;
      return v;
   endfunction

   task automatic chk(input string tag, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
      end
   endtask

   task automatic run(input string tag, input vec_t v);
      @(negedge clk);
      rst = v.rst; stall = v.stall; redirect_valid = v.rv; redirect_pc = v.rpc;
      imem_bus.imem_ready = v.rdy; imem_bus.imem_rdata = v.rdata;
      @(posedge clk);
      #1;
      chk(tag, "imem_req",   {31'd0, imem_bus.imem_req}, {31'd0, v.req});
      chk(tag, "imem_addr",  {22'd0, imem_bus.imem_addr}, {22'd0, v.addr});
      chk(tag, "inst_valid", {31'd0, inst_valid}, {31'd0, v.iv});
      chk(tag, "inst",       inst, v.inst);
      chk(tag, "inst_pc",    inst_pc, v.ipc);
      chk(tag, "pc",         pc, v.pc);
      chk(tag, "invalid_pc", {31'd0, invalid_pc}, {31'd0, v.inv});
      chk(tag, "bad_pc",     bad_pc, v.bad);
   endtask

   vec_t tbl[14];

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;

      //            rst st rv rpc           rdy rdata  req addr    iv inst ipc     pc            inv bad
      tbl[0]  = mk(1, 0, 0, 0,            0, 0,  1, 10'h000, 0, 0,  0,      R,            0, 0);
      tbl[1]  = mk(0, 0, 0, 0,            1, DA, 0, 10'h000, 1, DA, R,      R,            0, 0);
      tbl[2]  = mk(0, 0, 0, 0,            0, 0,  1, 10'h001, 0, DA, R,      R+4,          0, 0);
      tbl[3]  = mk(0, 0, 0, 0,            1, DB, 0, 10'h001, 1, DB, R+4,    R+4,          0, 0);
      tbl[4]  = mk(0, 1, 0, 0,            1, DC, 0, 10'h001, 1, DB, R+4,    R+4,          0, 0);
      tbl[5]  = mk(0, 1, 0, 0,            1, DC, 0, 10'h001, 1, DB, R+4,    R+4,          0, 0);
      tbl[6]  = mk(0, 1, 0, 0,            1, DC, 0, 10'h001, 1, DB, R+4,    R+4,          0, 0);
      tbl[7]  = mk(0, 0, 0, 0,            0, 0,  1, 10'h002, 0, DB, R+4,    R+8,          0, 0);
      tbl[8]  = mk(0, 0, 0, 0,            0, 0,  1, 10'h002, 0, DB, R+4,    R+8,          0, 0);
      tbl[9]  = mk(0, 0, 0, 0,            0, 0,  1, 10'h002, 0, DB, R+4,    R+8,          0, 0);
      tbl[10] = mk(0, 0, 1, 32'h00400100, 1, DC, 1, 10'h040, 0, DB, R+4,    32'h00400100, 0, 0);
      tbl[11] = mk(0, 0, 0, 0,            1, DD, 0, 10'h040, 1, DD, 32'h00400100, 32'h00400100, 0, 0);
      tbl[12] = mk(0, 1, 1, 32'h00400200, 1, DA, 1, 10'h080, 0, DD, 32'h00400100, 32'h00400200, 0, 0);
      tbl[13] = mk(1, 0, 1, 32'h00400300, 0, DA, 1, 10'h000, 0, 0,  0,      R,            0, 0);

      for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), tbl[i]);

      // Redirect out of the text segment.
      run("err_redir", mk(0, 0, 1, 32'h00500000, 1, DA, 0, 10'h000, 0, 0, 0, 32'h00500000, 0, 0));
      run("err_enter", mk(0, 0, 0, 0,            1, DA, 0, 10'h000, 0, 0, 0, 32'h00500000, 1, 32'h00500000));
`ifdef PC_FETCH_TRAP_EN
      run("err_trap",  mk(0, 1, 1, R,            1, DA, 1, 10'h060, 0, 0, 0, 32'h00400180, 0, 32'h00500000));
      run("err_post",  mk(0, 0, 0, 0,            0, 0,  1, 10'h060, 0, 0, 0, 32'h00400180, 0, 32'h00500000));
`else
      run("err_hold1", mk(0, 1, 1, R,            1, DA, 0, 10'h000, 0, 0, 0, 32'h00500000, 1, 32'h00500000));
      run("err_hold2", mk(0, 0, 1, R,            1, DA, 0, 10'h000, 0, 0, 0, 32'h00500000, 1, 32'h00500000));
`endif
      run("err_rst",   mk(1, 0, 0, 0,            0, 0,  1, 10'h000, 0, 0, 0, R, 0, 0));

      // Sequential increment past the last text word.
      run("end_redir", mk(0, 0, 1, 32'h00400FFC, 0, 0,  1, 10'h3FF, 0, 0,  0,            32'h00400FFC, 0, 0));
      run("end_fetch", mk(0, 0, 0, 0,            1, DE, 0, 10'h3FF, 1, DE, 32'h00400FFC, 32'h00400FFC, 0, 0));
      run("end_wrap",  mk(0, 0, 0, 0,            1, DA, 0, 10'h000, 0, DE, 32'h00400FFC, 32'h00401000, 0, 0));
      run("end_err",   mk(0, 0, 0, 0,            1, DA, 0, 10'h000, 0, DE, 32'h00400FFC, 32'h00401000, 1, 32'h00401000));
      run("end_rst",   mk(1, 0, 0, 0,            0, 0,  1, 10'h000, 0, 0,  0,            R,            0, 0));

      // Misaligned and below-base targets.
      run("mis_redir", mk(0, 0, 1, 32'h00400002, 1, DA, 0, 10'h000, 0, 0, 0, 32'h00400002, 0, 0));
      run("mis_err",   mk(0, 0, 0, 0,            1, DA, 0, 10'h000, 0, 0, 0, 32'h00400002, 1, 32'h00400002));
      run("mis_rst",   mk(1, 0, 0, 0,            0, 0,  1, 10'h000, 0, 0, 0, R, 0, 0));
      run("low_redir", mk(0, 0, 1, 32'h003FFFFC, 1, DA, 0, 10'h3FF, 0, 0, 0, 32'h003FFFFC, 0, 0));
      run("low_err",   mk(0, 0, 0, 0,            1, DA, 0, 10'h3FF, 0, 0, 0, 32'h003FFFFC, 1, 32'h003FFFFC));
      run("low_rst",   mk(1, 0, 0, 0,            0, 0,  1, 10'h000, 0, 0, 0, R, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h00400000, fetch address loaded on reset.
REQ-002 Parameter TEXT_BASE, 32'h00400000, lowest valid instruction address.
REQ-003 Parameter TEXT_LAST, 32'h00400FFF, highest valid instruction address.
REQ-004 Parameter TRAP_PC, 32'h00400180, redirect target on invalid PC (trap build only).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall  in  1  consumer not ready; hold delivered instruction.
REQ-008 redirect_valid  in  1  branch/jump taken this cycle.
REQ-009 redirect_pc  in  32  branch/jump target (virtual).
REQ-010 imem_req  out  1  instruction memory read request.
REQ-011 imem_addr  out  10  physical word address = pc[11:2].
REQ-012 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 inst_valid  out  1  inst/inst_pc valid for consumer.
REQ-015 inst  out  32  fetched instruction.
REQ-016 inst_pc  out  32  virtual address of inst.
REQ-017 pc  out  32  current fetch PC.
REQ-018 invalid_pc  out  1  invalid-PC error indication.
REQ-019 bad_pc  out  32  offending PC captured on error.

Function
REQ-020 FSM states SHALL be FETCH, DELIVER, ERROR, registered.
REQ-021 PC SHALL be invalid when pc < TEXT_BASE, pc > TEXT_LAST (unsigned 32-bit compare), or pc[1:0] != 0.
REQ-022 imem_req SHALL be 1 only in FETCH with valid pc; imem_addr SHALL be pc[11:2] combinationally in all states.
REQ-023 FETCH, pc invalid: next state ERROR, bad_pc <= pc, no request issued.
REQ-024 FETCH, pc valid, imem_ready=1, no redirect: inst <= imem_rdata, inst_pc <= pc, inst_valid <= 1, next DELIVER.
REQ-025 FETCH, imem_ready=0: hold imem_req and pc, remain FETCH (no timeout).
REQ-026 DELIVER, stall=1, no redirect: hold inst, inst_pc, inst_valid=1, pc.
REQ-027 DELIVER, stall=0: inst_valid <= 0, pc <= pc+4 (32-bit wrap), next FETCH.
REQ-028 redirect_valid=1 in FETCH or DELIVER SHALL win over stall and imem_ready: pc <= redirect_pc, inst_valid <= 0, next FETCH; same-cycle imem_rdata discarded.
REQ-029 ERROR: imem_req=0, inst_valid=0, redirect_valid and stall ignored.
REQ-030 Steady-state throughput with imem_ready tied 1 and stall=0: one instruction per 2 cycles, inst_valid 1 cycle after request.
REQ-031 pc+4 from TEXT_LAST-3 (32'h00400FFC) SHALL yield 32'h00401000, caught as invalid in next FETCH.

Reset
REQ-032 rst=1 at clock edge SHALL set state FETCH, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, invalid_pc=0, bad_pc=0, overriding all other inputs in any state including mid-fetch.
REQ-033 First imem_req SHALL assert in the cycle after rst deasserts.

Configuration
REQ-034 Macro PC_FETCH_TRAP_EN selects error handling.
REQ-035 Without PC_FETCH_TRAP_EN: ERROR is terminal until rst; invalid_pc=1 continuously while in ERROR.
REQ-036 With PC_FETCH_TRAP_EN: ERROR lasts exactly one cycle with invalid_pc=1, then pc <= TRAP_PC, next FETCH; bad_pc holds until next error or reset.

Verification
REQ-037 Reset, imem_ready=1, rdata=A,B, stall=0 -> imem_addr 0,1; inst A @inst_pc 0x00400000 then B @0x00400004, inst_valid every 2nd cycle.
REQ-038 stall=1 for 3 cycles in DELIVER -> inst, inst_pc, pc unchanged, inst_valid high 4 cycles, no imem_req.
REQ-039 redirect_pc=0x00400100 with imem_ready=1 in FETCH -> rdata dropped, next imem_addr=0x040, inst_valid stays 0.
REQ-040 redirect_pc=0x00500000 -> no imem_req, invalid_pc=1, bad_pc=0x00500000; without macro stays until rst, with macro 1-cycle pulse then imem_addr=0x060.
REQ-041 Sequential fetch to 0x00400FFC then stall=0 -> pc=0x00401000, ERROR, bad_pc=0x00401000; redirect_pc=0x00400002 also -> ERROR.
REQ-042 rst asserted while imem_ready=0 in FETCH -> next cycle pc=0x00400000, all outputs at reset values.
